ps2_key_event_receiver: RTL and testbench

//  Next-generation PS/2 keyboard front end: synchronises and filters ps2Clk/ps2Data, deserialises
//  11-bit frames with parity/stop checking and timeout recovery, folds E0/F0 prefixes into one key

---
 rtl/ps2_key_event_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_key_event_receiver.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_receiver.sv
// PS/2 keyboard front end: pin synchronisers, clock glitch filter, 11-bit frame receiver,
// E0/F0 prefix folding and a show-ahead event FIFO behind a valid/ready interface.
module ps2_key_event_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ps2Clk,
  input  logic                        ps2Data,
  input  logic                        eventReady,
  output logic                        eventValid,
  output logic [7:0]                  eventCode,
  output logic                        eventRelease,
  output logic                        eventExtended,
  output logic                        frameError,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: an event transfers on any cycle where eventValid && eventReady are both high;
  // eventValid never depends on eventReady, and eventReady without eventValid is ignored.

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic                   filt_level;
  logic [FW-1:0]          filt_cnt;
  logic                   fall;

  state_t                 state;
  state_t                 state_next;
  logic [2:0]             bit_cnt;
  logic [2:0]             bit_cnt_next;
  logic [7:0]             shreg;
  logic [7:0]             shreg_next;
  logic                   par_bit;
  logic                   par_next;
  logic                   accept;
  logic                   err;
  logic [TW-1:0]          to_cnt;

  logic                   accept_q;
  logic [7:0]             byte_q;
  logic                   ext_flag;
  logic                   rel_flag;
  logic                   push_req;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   pop;
  logic                   do_push;
  logic [9:0]             head;

  // Pins idle high, so the synchronisers come out of reset at 1 to avoid a spurious fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2Data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  assign fall = filt_level && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
    end else if (clk_s == filt_level) begin
      filt_cnt   <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_level <= clk_s;
      filt_cnt   <= '0;
    end else begin
      filt_cnt   <= filt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      accept_q <= 1'b0;
      byte_q   <= '0;
      frameError <= 1'b0;
    end else begin
      state    <= state_next;
      bit_cnt  <= bit_cnt_next;
      shreg    <= shreg_next;
      par_bit  <= par_next;
      accept_q <= accept;
      byte_q   <= shreg;
      frameError <= err;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    par_next     = par_bit;
    accept       = 1'b0;
    err          = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE: begin
          if (!data_s) begin
            state_next   = S_DATA;
            bit_cnt_next = '0;
          end else begin
            err = 1'b1;
          end
        end
        S_DATA: begin
          shreg_next   = {data_s, shreg[7:1]};
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_next = S_PARITY;
        end
        S_PARITY: begin
          par_next   = data_s;
          state_next = S_STOP;
        end
        S_STOP: begin
          if (data_s && (^{shreg, par_bit})) accept = 1'b1;
          else                               err    = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state != S_IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_next = S_IDLE;
      err        = 1'b1;
    end
  end

  // Counts only while a frame is open; any clock fall restarts the window.
  always_ff @(posedge clock) begin
    if (reset || state == S_IDLE || fall) to_cnt <= '0;
    else                                  to_cnt <= to_cnt + 1'b1;
  end

  assign push_req = accept_q && (byte_q != 8'hE0) && (byte_q != 8'hF0);

  always_ff @(posedge clock) begin
    if (reset || frameError) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else if (accept_q) begin
      if (byte_q == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (byte_q == 8'hF0) begin
        rel_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end
    end
  end

  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop     = eventValid && eventReady;
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {ext_flag, rel_flag, byte_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (!do_push && pop) count <= count - 1'b1;
      if (push_req && !do_push) overflow <= 1'b1;
    end
  end

  assign head          = mem[rd_ptr];
  assign eventValid    = (count != '0);
  assign eventCode     = eventValid ? head[7:0] : 8'h00;
  assign eventRelease  = eventValid && head[8];
  assign eventExtended = eventValid && head[9];
  assign fifoCount     = count;

endmodule

// File: tb/tb_ps2_key_event_receiver.sv
// Self-checking bench for ps2_key_event_receiver: PS/2 frame driver, byte-level event model
// with an expected queue, scenario tasks and a final report.
module tb_ps2_key_event_receiver;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int TMO   = 2000;
  localparam int HALF  = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic       eventReady;
  logic       eventValid;
  logic [7:0] eventCode;
  logic       eventRelease;
  logic       eventExtended;
  logic       frameError;
  logic       overflow;
  logic [3:0] fifoCount;

  ps2_key_event_receiver #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (SYNC),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ps2Clk       (ps2Clk),
    .ps2Data      (ps2Data),
    .eventReady   (eventReady),
    .eventValid   (eventValid),
    .eventCode    (eventCode),
    .eventRelease (eventRelease),
    .eventExtended(eventExtended),
    .frameError   (frameError),
    .overflow     (overflow),
    .fifoCount    (fifoCount)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int fe_pulses = 0;
  int fe_wide = 0;
  logic fe_prev = 1'b0;

  always @(negedge clock) begin
    if (frameError) begin
      fe_pulses++;
      if (fe_prev) fe_wide++;
    end
    fe_prev = frameError;
  end

  // ---------------- reference model ----------------
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;
  logic       m_ovf = 1'b0;
  logic [9:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      if (exp_q.size() == DEPTH) m_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_rel, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic model_error();
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  // ---------------- drivers ----------------
  logic       probe_a;
  logic       probe_b;
  logic [9:0] pulse_head;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // mode 1: one-cycle eventReady in the push cycle of the last bit; mode 2: sample eventValid around it
  task automatic send_bits(input logic [10:0] bits, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      tick(HALF);
      ps2Clk = 1'b0;
      if (i == n - 1 && mode == 1) begin
        tick(SYNC + FILT);
        pulse_head = {eventExtended, eventRelease, eventCode};
        eventReady = 1'b1;
        tick(1);
        eventReady = 1'b0;
        tick(HALF - SYNC - FILT - 1);
      end else if (i == n - 1 && mode == 2) begin
        tick(SYNC + FILT);
        probe_a = eventValid;
        tick(1);
        probe_b = eventValid;
        tick(HALF - SYNC - FILT - 1);
      end else begin
        tick(HALF);
      end
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int mode);
    logic        p;
    logic [10:0] bits;
    p    = (~^b) ^ bad_par;
    bits = {~bad_stop, p, b, 1'b0};
    send_bits(bits, 11, mode);
    tick(2 * HALF);
  endtask

  task automatic pop_event(output logic [9:0] ev, output bit got);
    int i = 0;
    while (!eventValid && i < 200) begin
      tick(1);
      i++;
    end
    got = eventValid;
    ev  = {eventExtended, eventRelease, eventCode};
    if (got) begin
      eventReady = 1'b1;
      tick(1);
      eventReady = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1; eventReady = 1'b0;
    tick(5);
    reset = 1'b0;
    tick(2);
    checks++;
    if ({eventValid, eventCode, eventRelease, eventExtended} !== 11'd0) begin
      errors++;
      $display("FAIL reset_event: got valid=%b code=%h rel=%b ext=%b want all 0",
               eventValid, eventCode, eventRelease, eventExtended);
    end
    checks++;
    if ({frameError, overflow, fifoCount} !== 6'd0) begin
      errors++;
      $display("FAIL reset_status: got fe=%b ovf=%b count=%0d want 0", frameError, overflow, fifoCount);
    end
  endtask

  task automatic test_single();
    logic [9:0] ev, exp;
    bit got;
    send_frame(8'h1C, 0, 0, 2);
    model_byte(8'h1C);
    checks++;
    if (probe_a !== 1'b0 || probe_b !== 1'b1) begin
      errors++;
      $display("FAIL latency: valid at push cycle=%b next=%b want 0,1", probe_a, probe_b);
    end
    checks++;
    if (fifoCount !== 4'd1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", fifoCount);
    end
    pop_event(ev, got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || ev !== exp) begin
      errors++;
      $display("FAIL single_event: got %h (valid=%b) want %h", ev, got, exp);
    end
    checks++;
    if (fifoCount !== 4'd0 || eventCode !== 8'h00) begin
      errors++;
      $display("FAIL single_drained: got count=%0d code=%h want 0,00", fifoCount, eventCode);
    end
  endtask

  task automatic test_prefix();
    logic [7:0] seq [5] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
    logic [9:0] ev, exp;
    bit got;
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], 0, 0, 0);
      model_byte(seq[i]);
    end
    checks++;
    if (fifoCount !== 4'(exp_q.size())) begin
      errors++;
      $display("FAIL prefix_count: got %0d want %0d", fifoCount, exp_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      pop_event(ev, got);
      exp = exp_q.pop_front();
      checks++;
      if (!got || ev !== exp) begin
        errors++;
        $display("FAIL prefix_event%0d: got %h (valid=%b) want %h", i, ev, got, exp);
      end
    end
  endtask

  task automatic test_errors();
    logic [9:0] ev, exp;
    bit got;
    int fe0 = fe_pulses;
    send_frame(8'h1C, 1, 0, 0);
    model_error();
    checks++;
    if (fe_pulses - fe0 !== 1 || fifoCount !== 4'd0) begin
      errors++;
      $display("FAIL parity_error: got pulses=%0d count=%0d want 1,0", fe_pulses - fe0, fifoCount);
    end
    send_frame(8'h1C, 0, 0, 0);
    model_byte(8'h1C);
    pop_event(ev, got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || ev !== exp) begin
      errors++;
      $display("FAIL after_parity: got %h (valid=%b) want %h", ev, got, exp);
    end
    send_frame(8'hE0, 0, 0, 0);
    model_byte(8'hE0);
    send_frame(8'h33, 0, 1, 0);
    model_error();
    send_frame(8'h75, 0, 0, 0);
    model_byte(8'h75);
    pop_event(ev, got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || ev !== exp) begin
      errors++;
      $display("FAIL stop_clears_prefix: got %h (valid=%b) want %h", ev, got, exp);
    end
    send_bits(11'h7FF, 1, 0);
    tick(2 * HALF);
    model_error();
    checks++;
    if (fe_pulses - fe0 !== 3) begin
      errors++;
      $display("FAIL bad_start: got pulses=%0d want 3", fe_pulses - fe0);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] ev, exp;
    bit got;
    int fe0 = fe_pulses;
    send_bits(11'b000_0010_1100, 6, 0);
    tick(TMO - 200);
    checks++;
    if (fe_pulses - fe0 !== 0) begin
      errors++;
      $display("FAIL timeout_early: got pulses=%0d want 0", fe_pulses - fe0);
    end
    tick(300);
    model_error();
    checks++;
    if (fe_pulses - fe0 !== 1) begin
      errors++;
      $display("FAIL timeout_pulse: got pulses=%0d want 1", fe_pulses - fe0);
    end
    send_frame(8'h29, 0, 0, 0);
    model_byte(8'h29);
    pop_event(ev, got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || ev !== exp) begin
      errors++;
      $display("FAIL after_timeout: got %h (valid=%b) want %h", ev, got, exp);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] ev, exp;
    bit got;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_frame(8'(i), 0, 0, 0);
      model_byte(8'(i));
    end
    checks++;
    if (fifoCount !== 4'(exp_q.size()) || overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow_fill: got count=%0d ovf=%b want %0d,%b", fifoCount, overflow, exp_q.size(), m_ovf);
    end
    send_frame(8'h0A, 0, 0, 1);
    exp = exp_q.pop_front();
    model_byte(8'h0A);
    checks++;
    if (pulse_head !== exp) begin
      errors++;
      $display("FAIL full_pushpop_head: got %h want %h", pulse_head, exp);
    end
    checks++;
    if (fifoCount !== 4'(exp_q.size())) begin
      errors++;
      $display("FAIL full_pushpop_count: got %0d want %0d", fifoCount, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      pop_event(ev, got);
      exp = exp_q.pop_front();
      checks++;
      if (!got || ev !== exp) begin
        errors++;
        $display("FAIL drain: got %h (valid=%b) want %h", ev, got, exp);
      end
    end
    checks++;
    if (fifoCount !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got count=%0d ovf=%b want 0,1", fifoCount, overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] ev, exp;
    bit got;
    send_frame(8'h11, 0, 0, 0);
    send_frame(8'h22, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_bits(11'b000_0011_0110, 5, 0);
    reset = 1'b1;
    tick(2);
    checks++;
    if ({eventValid, eventCode, eventRelease, eventExtended, frameError, overflow, fifoCount} !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b code=%h ovf=%b count=%0d want all 0",
               eventValid, eventCode, overflow, fifoCount);
    end
    reset = 1'b0;
    exp_q.delete();
    model_error();
    m_ovf = 1'b0;
    tick(2);
    send_frame(8'h1C, 0, 0, 0);
    model_byte(8'h1C);
    pop_event(ev, got);
    exp = exp_q.pop_front();
    checks++;
    if (!got || ev !== exp) begin
      errors++;
      $display("FAIL after_reset_mid: got %h (valid=%b) want %h", ev, got, exp);
    end
  endtask

  task automatic test_random();
    logic [9:0] ev, exp;
    logic [7:0] b;
    bit got;
    bit bad;
    int fe0 = fe_pulses;
    int fe_exp = 0;
    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else            b = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0);
      send_frame(b, bad, 0, 0);
      if (bad) begin
        model_error();
        fe_exp++;
      end else begin
        model_byte(b);
      end
      if (exp_q.size() >= 3 || n == 39) begin
        while (exp_q.size() > 0) begin
          pop_event(ev, got);
          exp = exp_q.pop_front();
          checks++;
          if (!got || ev !== exp) begin
            errors++;
            $display("FAIL random_event: got %h (valid=%b) want %h", ev, got, exp);
          end
        end
      end
    end
    checks++;
    if (fe_pulses - fe0 !== fe_exp || fifoCount !== 4'd0 || overflow !== m_ovf) begin
      errors++;
      $display("FAIL random_status: got pulses=%0d count=%0d ovf=%b want %0d,0,%b",
               fe_pulses - fe0, fifoCount, overflow, fe_exp, m_ovf);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_errors();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    checks++;
    if (fe_wide !== 0) begin
      errors++;
      $display("FAIL frame_error_width: got %0d multi-cycle pulses want 0", fe_wide);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
